// File: rtl/ram_rr_arbiter_if.sv
// Core-side bus of the shared-RAM arbiter: packed per-core request fields in,
// one-hot completion pulse and shared read data out.
interface ram_rr_arbiter_if #(
  parameter int NCORES = 2,
  parameter int AW     = 8,
  parameter int DW     = 8
);
  // Handshake: a core raises req (level) with we/addr/wdata stable and holds it
  // until it sees its ack bit; ack is a single-cycle pulse, and the core drops req
  // at the edge where it samples ack. rdata is valid in the ack cycle of a read.
  logic [NCORES-1:0]    req;
  logic [NCORES-1:0]    we;
  logic [NCORES*AW-1:0] addr;
  logic [NCORES*DW-1:0] wdata;
  logic [NCORES-1:0]    ack;
  logic [DW-1:0]        rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_rr_arbiter.sv
// Round-robin sequencer sharing one single-port synchronous RAM between NCORES
// cores: one RAM cycle per grant, RAM_LAT wait for reads, one-cycle ack.
module ram_rr_arbiter #(
  parameter int NCORES  = 2,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int RAM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ram_rr_arbiter_if.slave           core,
  output logic [$clog2(NCORES)-1:0] grant_id,
  output logic                      busy,
  output logic [1:0]                dbg_state,
  output logic [AW-1:0]             ram_addr,
  output logic [DW-1:0]             ram_din,
  output logic                      ram_wren,
  input  logic [DW-1:0]             ram_q
);

  localparam int IW = $clog2(NCORES);
  localparam int NP = 2 ** IW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   sel;
  logic            found;
  logic            wr_q;
  logic [1:0]      cnt_q;
  logic [NCORES-1:0] one_hot;

  // Per-core fields padded to a power of two so any IW-bit index is in range.
  logic [NP-1:0]   req_p;
  logic [NP-1:0]   we_p;
  logic [AW-1:0]   addr_a  [NP];
  logic [DW-1:0]   wdata_a [NP];

  for (genvar i = 0; i < NP; i++) begin : g_unpack
    if (i < NCORES) begin : g_core
      assign req_p[i]   = core.req[i];
      assign we_p[i]    = core.we[i];
      assign addr_a[i]  = core.addr[i*AW +: AW];
      assign wdata_a[i] = core.wdata[i*DW +: DW];
    end else begin : g_pad
      assign req_p[i]   = 1'b0;
      assign we_p[i]    = 1'b0;
      assign addr_a[i]  = '0;
      assign wdata_a[i] = '0;
    end
  end

  // First requester at or above ptr, wrapping modulo NCORES.
  always_comb begin : arb
    logic [IW:0] cand;
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NCORES; i++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NCORES)) cand = cand - (IW+1)'(NCORES);
      if (!found && req_p[cand[IW-1:0]]) begin
        found = 1'b1;
        sel   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    one_hot = '0;
    for (int i = 0; i < NCORES; i++) one_hot[i] = (grant_id == IW'(i));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = ISSUE;
      ISSUE:   state_d = wr_q ? DONE : WAIT;
      WAIT:    if (cnt_q == 2'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      wr_q       <= 1'b0;
      cnt_q      <= 2'd0;
      grant_id   <= '0;
      busy       <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_wren   <= 1'b0;
      core.ack   <= '0;
      core.rdata <= '0;
    end else begin
      busy     <= (state_d != IDLE);
      ram_wren <= 1'b0;
      core.ack <= '0;
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_id <= sel;
            ram_addr <= addr_a[sel];
            ram_din  <= wdata_a[sel];
            wr_q     <= we_p[sel];
            ram_wren <= we_p[sel];
          end
        end
        ISSUE: cnt_q <= 2'(RAM_LAT - 1);
        WAIT: begin
          if (cnt_q != 2'd0) cnt_q <= cnt_q - 2'd1;
          else               core.rdata <= ram_q;
        end
        DONE: ptr_q <= (grant_id == IW'(NCORES - 1)) ? '0 : grant_id + 1'b1;
        default: ;
      endcase
      if (state_d == DONE) core.ack <= one_hot;
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: three 4-core instances with RAM_LAT 1,2,3 share the
// same stimulus; each has its own RAM model and its own view of the scoreboard.
module tb_ram_rr_arbiter;
  localparam int NI = 3;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_v [NI];
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [3:0]  ack_v      [NI];
  logic [7:0]  rdata_v    [NI];
  logic [1:0]  gid_v      [NI];
  logic        busy_v     [NI];
  logic [1:0]  st_v       [NI];
  logic [7:0]  ram_addr_v [NI];
  logic [7:0]  ram_din_v  [NI];
  logic        ram_wren_v [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    ram_rr_arbiter_if #(.NCORES(4), .AW(8), .DW(8)) bus ();
    logic [1:0] gid_l;
    logic       busy_l, wren_l;
    logic [1:0] st_l;
    logic [7:0] raddr_l, rdin_l;
    logic [7:0] mem [256];
    logic [7:0] qp [k+1];

    assign bus.req   = req_v[k];
    assign bus.we    = we;
    assign bus.addr  = addr;
    assign bus.wdata = wdata;

    ram_rr_arbiter #(.NCORES(4), .AW(8), .DW(8), .RAM_LAT(k+1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .core      (bus.slave),
      .grant_id  (gid_l),
      .busy      (busy_l),
      .dbg_state (st_l),
      .ram_addr  (raddr_l),
      .ram_din   (rdin_l),
      .ram_wren  (wren_l),
      .ram_q     (qp[k])
    );

    // Synchronous RAM with RAM_LAT-1 extra output register stages.
    always @(posedge clk) begin
      if (wren_l) mem[raddr_l] <= rdin_l;
      qp[0] <= mem[raddr_l];
      for (int j = 1; j <= k; j++) qp[j] <= qp[j-1];
    end

    assign ack_v[k]      = bus.ack;
    assign rdata_v[k]    = bus.rdata;
    assign gid_v[k]      = gid_l;
    assign busy_v[k]     = busy_l;
    assign st_v[k]       = st_l;
    assign ram_addr_v[k] = raddr_l;
    assign ram_din_v[k]  = rdin_l;
    assign ram_wren_v[k] = wren_l;
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: record = {core[1:0], is_read, data[7:0]}
  logic [10:0] exp_q [$];
  int          sb_idx      [NI];
  logic [7:0]  last_rd     [NI];
  int          ack_cyc     [NI];
  logic [7:0]  addr_at_ack [NI];
  int          wren_cnt    [NI];
  logic [7:0]  wr_addr     [NI];
  logic [7:0]  wr_din      [NI];
  logic [3:0]  reraise     [NI];
  int          done_cnt    [NI][4];
  bit          auto_on;
  int          ncyc;
  int          n_checks;
  int          n_errors;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s [lat%0d] @%0t: got 0x%0h, expected 0x%0h", name, k+1, $time, act, exp_v);
    end
  endtask

  function automatic bit all_done();
    bit d = 1'b1;
    for (int k = 0; k < NI; k++) if (sb_idx[k] != exp_q.size()) d = 1'b0;
    return d;
  endfunction

  // One clock: sample at the falling edge, score acks, drop/re-raise requests.
  task automatic cycle();
    logic [10:0] e;
    @(negedge clk);
    ncyc++;
    for (int k = 0; k < NI; k++) begin
      req_v[k]   = req_v[k] | reraise[k];
      reraise[k] = 4'b0;
      if (ram_wren_v[k]) begin
        wren_cnt[k]++;
        wr_addr[k] = ram_addr_v[k];
        wr_din[k]  = ram_din_v[k];
      end
      if (ack_v[k] != 4'b0) begin
        if (sb_idx[k] >= exp_q.size()) begin
          chk("unexpected_ack", k, 32'(ack_v[k]), 32'd0);
        end else begin
          e = exp_q[sb_idx[k]];
          sb_idx[k]++;
          chk("ack", k, 32'(ack_v[k]), 32'(4'b0001 << e[10:9]));
          chk("grant_id", k, 32'(gid_v[k]), 32'(e[10:9]));
          if (e[8]) begin
            chk("rdata", k, 32'(rdata_v[k]), 32'(e[7:0]));
            last_rd[k] = e[7:0];
          end else begin
            chk("rdata_hold", k, 32'(rdata_v[k]), 32'(last_rd[k]));
          end
          done_cnt[k][e[10:9]]++;
          if (auto_on && done_cnt[k][e[10:9]] < 2) reraise[k][e[10:9]] = 1'b1;
        end
        ack_cyc[k]     = ncyc;
        addr_at_ack[k] = ram_addr_v[k];
        req_v[k]       = req_v[k] & ~ack_v[k];
      end
    end
  endtask

  task automatic wait_all(input int budget);
    int n = 0;
    while (!all_done() && n < budget) begin
      cycle();
      n++;
    end
    if (!all_done()) begin
      for (int k = 0; k < NI; k++) begin
        chk("timeout_pending", k, 32'(exp_q.size() - sb_idx[k]), 32'd0);
        sb_idx[k] = exp_q.size();
      end
    end
    cycle();
  endtask

  task automatic push_exp(input int c, input bit wr, input logic [7:0] d);
    logic [1:0] c2 = c[1:0];
    exp_q.push_back({c2, ~wr, wr ? 8'h00 : d});
  endtask

  task automatic drive_core(input int c, input bit wr, input logic [7:0] a,
                            input logic [7:0] d);
    addr[c*8 +: 8]  = a;
    wdata[c*8 +: 8] = d;
    we[c]           = wr;
    for (int k = 0; k < NI; k++) req_v[k][c] = 1'b1;
  endtask

  // Single-core transaction with latency, RAM-port and busy checks.
  task automatic run_txn(input int c, input bit wr, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] exp_rd);
    int n0;
    for (int k = 0; k < NI; k++) wren_cnt[k] = 0;
    drive_core(c, wr, a, d);
    push_exp(c, wr, exp_rd);
    n0 = ncyc;
    wait_all(40);
    for (int k = 0; k < NI; k++) begin
      chk("latency", k, 32'(ack_cyc[k] - n0), wr ? 32'd2 : 32'(k + 3));
      chk("wren_cycles", k, 32'(wren_cnt[k]), wr ? 32'd1 : 32'd0);
      if (wr) begin
        chk("wr_addr", k, 32'(wr_addr[k]), 32'(a));
        chk("wr_din", k, 32'(wr_din[k]), 32'(d));
      end else begin
        chk("ram_addr_hold", k, 32'(addr_at_ack[k]), 32'(a));
      end
      chk("busy_after", k, 32'(busy_v[k]), 32'd0);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk({tag, "_ack"}, k, 32'(ack_v[k]), 32'd0);
      chk({tag, "_rdata"}, k, 32'(rdata_v[k]), 32'd0);
      chk({tag, "_grant_id"}, k, 32'(gid_v[k]), 32'd0);
      chk({tag, "_busy"}, k, 32'(busy_v[k]), 32'd0);
      chk({tag, "_ram_addr"}, k, 32'(ram_addr_v[k]), 32'd0);
      chk({tag, "_ram_din"}, k, 32'(ram_din_v[k]), 32'd0);
      chk({tag, "_ram_wren"}, k, 32'(ram_wren_v[k]), 32'd0);
      chk({tag, "_state"}, k, 32'(st_v[k]), 32'd0);
    end
  endtask

  typedef struct {
    int         core;
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t       vt [12];
  logic [7:0] ref_mem [8];

  initial begin
    vt[0]  = '{1, 1'b1, 8'h3C, 8'hA5, 8'h00};
    vt[1]  = '{1, 1'b0, 8'h3C, 8'h00, 8'hA5};
    vt[2]  = '{0, 1'b1, 8'h10, 8'h5A, 8'h00};
    vt[3]  = '{2, 1'b1, 8'h20, 8'hC3, 8'h00};
    vt[4]  = '{3, 1'b0, 8'h10, 8'h00, 8'h5A};
    vt[5]  = '{0, 1'b0, 8'h20, 8'h00, 8'hC3};
    vt[6]  = '{2, 1'b1, 8'hFF, 8'h01, 8'h00};
    vt[7]  = '{3, 1'b1, 8'h00, 8'hFF, 8'h00};
    vt[8]  = '{1, 1'b0, 8'hFF, 8'h00, 8'h01};
    vt[9]  = '{2, 1'b0, 8'h00, 8'h00, 8'hFF};
    vt[10] = '{0, 1'b1, 8'h3C, 8'h77, 8'h00};
    vt[11] = '{3, 1'b0, 8'h3C, 8'h00, 8'h77};

    n_checks = 0;
    n_errors = 0;
    ncyc     = 0;
    auto_on  = 1'b0;
    for (int k = 0; k < NI; k++) begin
      sb_idx[k]  = 0;
      last_rd[k] = 8'h00;
      reraise[k] = 4'b0;
      ack_cyc[k] = 0;
      wren_cnt[k] = 0;
      for (int c = 0; c < 4; c++) done_cnt[k][c] = 0;
    end

    // Reset with random inputs: every output must stay zero.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NI; k++) req_v[k] = 4'($urandom_range(0, 15));
      we    = 4'($urandom_range(0, 15));
      addr  = $urandom;
      wdata = $urandom;
      @(negedge clk);
    end
    chk_zero("reset");
    for (int k = 0; k < NI; k++) req_v[k] = 4'b0;
    we = 4'b0;
    rst_n = 1'b1;
    cycle();
    cycle();
    for (int k = 0; k < NI; k++) begin
      chk("post_reset_busy", k, 32'(busy_v[k]), 32'd0);
      chk("post_reset_state", k, 32'(st_v[k]), 32'd0);
    end

    // Table of single-core writes and reads.
    for (int i = 0; i < 12; i++) run_txn(vt[i].core, vt[i].wr, vt[i].a, vt[i].d, vt[i].exp_rd);

    // Random traffic over a small address window with a reference memory.
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = 8'($urandom_range(0, 255));
      run_txn(i % 4, 1'b1, 8'(8'h40 + i), ref_mem[i], 8'h00);
    end
    for (int n = 0; n < 12; n++) begin
      int         c   = $urandom_range(0, 3);
      int         i   = $urandom_range(0, 7);
      bit         wr  = 1'($urandom_range(0, 1));
      logic [7:0] d   = 8'($urandom_range(0, 255));
      if (wr) begin
        ref_mem[i] = d;
        run_txn(c, 1'b1, 8'(8'h40 + i), d, 8'h00);
      end else begin
        run_txn(c, 1'b0, 8'(8'h40 + i), 8'h00, ref_mem[i]);
      end
    end

    // Leave ptr at 0, then all four cores request continuously, two rounds each.
    run_txn(3, 1'b1, 8'h90, 8'h33, 8'h00);
    for (int c = 0; c < 4; c++) begin
      addr[c*8 +: 8]  = 8'(8'h80 + c);
      wdata[c*8 +: 8] = 8'(8'hB0 + c);
    end
    we = 4'hF;
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < 4; c++) done_cnt[k][c] = 0;
      req_v[k] = 4'hF;
    end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) push_exp(c, 1'b1, 8'h00);
    auto_on = 1'b1;
    wait_all(200);
    auto_on = 1'b0;
    cycle();
    for (int k = 0; k < NI; k++) chk("rr_idle_after", k, 32'(busy_v[k]), 32'd0);

    // Mid-transaction: address change and request withdrawal are ignored.
    drive_core(0, 1'b0, 8'h10, 8'h00);
    push_exp(0, 1'b0, 8'h5A);
    cycle();
    cycle();
    addr[7:0] = 8'h20;
    for (int k = 0; k < NI; k++) req_v[k][0] = 1'b0;
    wait_all(40);
    for (int k = 0; k < NI; k++) begin
      chk("mid_ram_addr", k, 32'(addr_at_ack[k]), 32'h10);
      chk("mid_busy_after", k, 32'(busy_v[k]), 32'd0);
    end

    // Reset during WAIT: the read is abandoned and ptr returns to 0.
    for (int k = 0; k < NI; k++) wren_cnt[k] = 0;
    drive_core(0, 1'b0, 8'h3C, 8'h00);
    cycle();
    cycle();
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      req_v[k]   = 4'b0;
      last_rd[k] = 8'h00;
    end
    #1;
    chk_zero("midreset");
    repeat (3) cycle();
    for (int k = 0; k < NI; k++) chk("midreset_wren", k, 32'(wren_cnt[k]), 32'd0);
    rst_n = 1'b1;
    cycle();
    for (int k = 0; k < NI; k++) chk("release_state", k, 32'(st_v[k]), 32'd0);
    drive_core(1, 1'b1, 8'h51, 8'h22);
    drive_core(0, 1'b1, 8'h50, 8'h11);
    push_exp(0, 1'b1, 8'h00);
    push_exp(1, 1'b1, 8'h00);
    wait_all(40);
    run_txn(2, 1'b0, 8'h50, 8'h00, 8'h11);
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
